slv_guard_txn_watchdog: RTL

Parametrised per-ID transaction watchdog for one AXI direction (AW/B or AR/R), successor to the fixed two-ID guard. It keeps a per-ID FIFO of outstanding transactions, holding a start timestamp and address for each, and checks the head entry of every ID against a runtime budget. On a fault it raises irq, reports the ID, address and cause, isolates the subordinate, and runs a reset request/acknowledge handshake before resuming. It sits between the ID remapper and the subordinate and observes handshakes only; the parent gates the bus with isolate_o and stall_o.

---
 rtl/slv_guard_txn_watchdog.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/slv_guard_txn_watchdog.sv
`default_nettype none
// ============================================================================
// Module : slv_guard_txn_watchdog
// Per-ID outstanding-transaction watchdog with fault capture and reset handshake.
// Rev    : 1.0
// ============================================================================
module slv_guard_txn_watchdog #(
  parameter int unsigned IdWidth      = 2,
  parameter int unsigned TxnsPerId    = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned CntWidth     = 10,
  parameter int unsigned PrescalerDiv = 4,
  localparam int unsigned NumIds      = 2**IdWidth,
  localparam int unsigned OutW        = $clog2(NumIds*TxnsPerId+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 req_valid_i,
  input  logic                 req_ready_i,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 rsp_valid_i,
  input  logic                 rsp_ready_i,
  input  logic [IdWidth-1:0]   rsp_id_i,
  input  logic                 rsp_last_i,
  input  logic [CntWidth-1:0]  budget_i,
  output logic                 stall_o,
  output logic                 isolate_o,
  output logic                 irq_o,
  output logic [1:0]           irq_cause_o,
  output logic [IdWidth-1:0]   irq_id_o,
  output logic [AddrWidth-1:0] irq_addr_o,
  input  logic                 irq_clear_i,
  output logic                 rst_req_o,
  input  logic                 rst_stat_i,
  output logic [OutW-1:0]      outstanding_o
);

  localparam int unsigned c_PTR_W = (TxnsPerId > 1) ? $clog2(TxnsPerId) : 1;
  localparam int unsigned c_OCC_W = $clog2(TxnsPerId + 1);
  localparam int unsigned c_PRE_W = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

  localparam logic [1:0] c_MON     = 2'd0;
  localparam logic [1:0] c_FAULT   = 2'd1;
  localparam logic [1:0] c_RECOVER = 2'd2;

  localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] c_CAUSE_SPUR    = 2'b10;
  localparam logic [1:0] c_CAUSE_OVF     = 2'b11;

  logic [1:0]           r_state, w_state_nxt;
  logic [c_PRE_W-1:0]   r_presc;
  logic [CntWidth-1:0]  r_ts;
  logic                 r_irq;
  logic [1:0]           r_cause;
  logic [IdWidth-1:0]   r_irq_id;
  logic [AddrWidth-1:0] r_irq_addr;

  logic                 w_tick, w_active, w_req_hs, w_rsp_last, w_same_id;
  logic                 w_push_ok, w_pop_ok, w_ovf, w_spur, w_flush, w_fault;
  logic                 w_to_any;
  logic [IdWidth-1:0]   w_to_id;
  logic [NumIds-1:0]    w_full, w_empty, w_to;
  logic [c_OCC_W-1:0]   w_occ       [NumIds];
  logic [CntWidth-1:0]  w_head_ts   [NumIds];
  logic [AddrWidth-1:0] w_head_addr [NumIds];
  logic [1:0]           w_cause;
  logic [IdWidth-1:0]   w_cap_id;
  logic [AddrWidth-1:0] w_cap_addr;
  logic [OutW-1:0]      w_total;

  assign w_tick = (r_presc == c_PRE_W'(PrescalerDiv - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc <= '0;
      r_ts    <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_ts    <= r_ts + CntWidth'(1);
    end else begin
      r_presc <= r_presc + c_PRE_W'(1);
    end
  end

  assign w_active   = (r_state == c_MON) && enable_i;
  assign w_req_hs   = req_valid_i && req_ready_i;
  assign w_rsp_last = rsp_valid_i && rsp_ready_i && rsp_last_i;
  assign w_same_id  = w_rsp_last && (rsp_id_i == req_id_i);

  // A same-cycle pop on the requesting ID frees the slot the push needs.
  assign stall_o   = w_full[req_id_i] && !w_same_id;
  assign w_push_ok = w_active && w_req_hs && !stall_o;
  assign w_ovf     = w_active && w_req_hs && stall_o;
  assign w_pop_ok  = w_active && w_rsp_last && !w_empty[rsp_id_i];
  assign w_spur    = w_active && w_rsp_last && w_empty[rsp_id_i];
  assign w_flush   = ((r_state == c_MON) && !enable_i) ||
                     ((r_state == c_FAULT) && rst_stat_i);

  for (genvar g = 0; g < NumIds; g++) begin : g_id
    logic [c_PTR_W-1:0]   r_wptr, r_rptr;
    logic [c_OCC_W-1:0]   r_occ;
    logic [CntWidth-1:0]  r_ts_mem   [TxnsPerId];
    logic [AddrWidth-1:0] r_addr_mem [TxnsPerId];
    logic                 w_push, w_pop;

    assign w_push         = w_push_ok && (req_id_i == IdWidth'(g));
    assign w_pop          = w_pop_ok && (rsp_id_i == IdWidth'(g));
    assign w_occ[g]       = r_occ;
    assign w_full[g]      = (r_occ == c_OCC_W'(TxnsPerId));
    assign w_empty[g]     = (r_occ == '0);
    assign w_head_ts[g]   = r_ts_mem[r_rptr];
    assign w_head_addr[g] = r_addr_mem[r_rptr];
    assign w_to[g]        = !w_empty[g] && ((r_ts - r_ts_mem[r_rptr]) > budget_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else begin
        if (w_push) r_wptr <= (r_wptr == c_PTR_W'(TxnsPerId - 1)) ? '0 : r_wptr + c_PTR_W'(1);
        if (w_pop)  r_rptr <= (r_rptr == c_PTR_W'(TxnsPerId - 1)) ? '0 : r_rptr + c_PTR_W'(1);
        if (w_push && !w_pop)      r_occ <= r_occ + c_OCC_W'(1);
        else if (!w_push && w_pop) r_occ <= r_occ - c_OCC_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push) begin
        r_ts_mem[r_wptr]   <= r_ts;
        r_addr_mem[r_wptr] <= req_addr_i;
      end
    end
  end

  // Descending scan so the lowest timed-out ID is the one left standing.
  always_comb begin
    w_to_any = 1'b0;
    w_to_id  = '0;
    for (int i = int'(NumIds) - 1; i >= 0; i--) begin
      if (w_to[i]) begin
        w_to_any = 1'b1;
        w_to_id  = IdWidth'(i);
      end
    end
  end

  assign w_fault = w_active && (w_to_any || w_ovf || w_spur);

  always_comb begin
    w_cause    = c_CAUSE_SPUR;
    w_cap_id   = rsp_id_i;
    w_cap_addr = '0;
    if (w_to_any) begin
      w_cause    = c_CAUSE_TIMEOUT;
      w_cap_id   = w_to_id;
      w_cap_addr = w_head_addr[w_to_id];
    end else if (w_ovf) begin
      w_cause    = c_CAUSE_OVF;
      w_cap_id   = req_id_i;
      w_cap_addr = w_head_addr[req_id_i];
    end
  end

  always_comb begin
    w_total = '0;
    for (int i = 0; i < int'(NumIds); i++) w_total = w_total + OutW'(w_occ[i]);
  end
  assign outstanding_o = w_total;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= c_MON;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_MON:     if (w_fault) w_state_nxt = c_FAULT;
      c_FAULT:   if (rst_stat_i) w_state_nxt = c_RECOVER;
      c_RECOVER: if (!rst_stat_i && !r_irq) w_state_nxt = c_MON;
      default:   w_state_nxt = c_MON;
    endcase
  end

  always_comb begin
    isolate_o = (r_state != c_MON);
    rst_req_o = (r_state == c_FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq      <= 1'b0;
      r_cause    <= '0;
      r_irq_id   <= '0;
      r_irq_addr <= '0;
    end else if ((r_state == c_MON) && w_fault) begin
      r_irq      <= 1'b1;
      r_cause    <= w_cause;
      r_irq_id   <= w_cap_id;
      r_irq_addr <= w_cap_addr;
    end else if ((r_state == c_RECOVER) && irq_clear_i) begin
      r_irq      <= 1'b0;
    end
  end

  assign irq_o       = r_irq;
  assign irq_cause_o = r_cause;
  assign irq_id_o    = r_irq_id;
  assign irq_addr_o  = r_irq_addr;

endmodule
`default_nettype wire
